mpsoc_uart_rx: RTL and testbench
================================

MPSOC_UART_RX -- requirements
Module: mpsoc_uart_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of flip-flop stages synchronising rx_i (legal values 2..4).
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port rx_i, input, 1 bit: asynchronous serial line; idles high.
REQ-005 SHALL have port busy_o, output, 1 bit: high whenever the state is not IDLE.
REQ-006 SHALL have port cfg_en_i, input, 1 bit: receiver enable.
REQ-007 SHALL have port cfg_div_i, input, 16 bits: bit period P = cfg_div_i+1 clocks.
REQ-008 SHALL have port cfg_parity_en_i, input, 1 bit: parity bit present, even parity.
REQ-009 SHALL have port cfg_bits_i, input, 2 bits: data bits = 5 + cfg_bits_i.
REQ-010 SHALL have port cfg_stop_bits_i, input, 1 bit: 0 = one stop bit, 1 = two stop bits.
REQ-011 SHALL have port rx_data_o, output, 8 bits: received word, LSB-aligned, unused upper bits 0.
REQ-012 SHALL have port rx_valid_o, output, 1 bit: rx_data_o and error flags valid.
REQ-013 SHALL have port rx_ready_i, input, 1 bit: consumer accepts the word.
REQ-014 SHALL have port err_parity_o, output, 1 bit: parity mismatch on the held word; qualified by rx_valid_o.
REQ-015 SHALL have port err_frame_o, output, 1 bit: a stop bit sampled low on the held word; qualified by rx_valid_o.
REQ-016 SHALL have port err_overrun_o, output, 1 bit: one-cycle pulse when an unconsumed word is overwritten.

Function
REQ-017 SHALL sample rx_i only through the SYNC_STAGES synchroniser, whose flops reset to 1; "line" below means the synchroniser output.
REQ-018 SHALL implement the states IDLE, START, DATA, PARITY, STOP1 and STOP2, plus a 16-bit baud counter and a 3-bit bit counter.
REQ-019 IDLE: a falling edge on line with cfg_en_i=1 SHALL enter START, clear the baud counter and latch all cfg_* inputs for the frame.
REQ-020 START: when the baud counter equals cfg_div_i[15:1], the block SHALL sample line; if line=1 (glitch) it SHALL return to IDLE with no output; if line=0 it SHALL enter DATA and clear the counter.
REQ-021 In DATA, PARITY and STOP states, the block SHALL sample line when the counter equals the latched divider, clear the counter, and otherwise increment it, so samples fall mid-bit every P clocks.
REQ-022 DATA: samples SHALL shift in LSB first; after 5+cfg_bits samples the block SHALL go to PARITY if parity is enabled, else to STOP1.
REQ-023 PARITY: the block SHALL flag a parity error when the sampled bit differs from the XOR of the received data bits.
REQ-024 STOP1 SHALL go to STOP2 if two stop bits are configured, else complete the frame; STOP2 SHALL complete the frame; any stop sample of 0 SHALL flag a framing error.
REQ-025 On frame completion the block SHALL return to IDLE in the same cycle as the final stop sample, so the next start edge is detectable immediately.
REQ-026 In the cycle after completion, the block SHALL load rx_data_o, err_parity_o and err_frame_o and set rx_valid_o; words with errors SHALL still be delivered.
REQ-027 rx_valid_o SHALL stay high, with outputs stable, until a cycle with rx_ready_i=1, and SHALL fall on the following edge.
REQ-028 If a completion load occurs while rx_valid_o=1 and rx_ready_i=0, the block SHALL overwrite the held word, keep rx_valid_o=1 and pulse err_overrun_o for exactly one cycle; completion coincident with rx_ready_i=1 SHALL load the new word with no overrun.
REQ-029 If cfg_en_i=0, the block SHALL force IDLE on the next edge and discard the partial frame; the held word and rx_valid_o SHALL be unaffected.
REQ-030 With cfg_div_i=0 (P=1), the block SHALL still operate, sampling every clock.

Reset
REQ-031 When rst_i=1, the block SHALL enter IDLE and clear both counters, rx_data_o, rx_valid_o, err_parity_o, err_frame_o and err_overrun_o; busy_o SHALL be 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame; after release, no word SHALL be delivered until a new start edge occurs.

Verification
REQ-033 cfg_div_i=15, 8 data bits, no parity, 1 stop bit, line byte 0xA5 -> rx_valid_o=1 with rx_data_o=0xA5 and no error flags; busy_o=0 after the stop sample.
REQ-034 5 data bits, parity enabled, data 0x13 sent with parity 0 -> rx_data_o=0x13 and err_parity_o=1.
REQ-035 2 stop bits, second stop bit driven 0 -> err_frame_o=1 and the word is still delivered.
REQ-036 Low pulse of fewer than P/2 clocks on an idle line -> return to IDLE with rx_valid_o remaining 0.
REQ-037 Two back-to-back frames (0x11 then 0x22) with rx_ready_i=0 -> err_overrun_o pulses once and rx_data_o=0x22.
REQ-038 rst_i pulsed in the middle of DATA -> all outputs 0, and the next clean frame 0x3C is received correctly.

Source files
------------

// File: rtl/mpsoc_uart_rx.sv
// ---------------------------------------------------------------------------
// mpsoc_uart_rx
//   Configurable UART receiver. The frame is 1 start bit, 5..8 data bits sent
//   LSB first, an optional even-parity bit, and 1 or 2 stop bits. The bit
//   period is cfg_div_i+1 clocks. Each completed frame is presented on a
//   valid/ready holding register. A new word that overwrites an unconsumed
//   one raises a single-cycle overrun pulse.
//
// Ports
//   clk_i            clock, rising edge
//   rst_i            asynchronous active-high reset
//   rx_i             asynchronous serial input, idles high
//   busy_o           receiver is inside a frame (state not IDLE)
//   cfg_en_i         receiver enable; low aborts any frame in progress
//   cfg_div_i        bit period minus one, in clocks
//   cfg_parity_en_i  even-parity bit present
//   cfg_bits_i       data bits minus five
//   cfg_stop_bits_i  0: one stop bit, 1: two stop bits
//   rx_data_o        received word, LSB aligned, unused upper bits zero
//   rx_valid_o       rx_data_o and the error flags hold a word
//   rx_ready_i       consumer accepts the held word
//   err_parity_o     parity mismatch on the held word
//   err_frame_o      a stop bit of the held word was sampled low
//   err_overrun_o    one-cycle pulse when an unconsumed word is overwritten
// ---------------------------------------------------------------------------
module mpsoc_uart_rx #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_i,
    output logic        busy_o,
    input  logic        cfg_en_i,
    input  logic [15:0] cfg_div_i,
    input  logic        cfg_parity_en_i,
    input  logic [1:0]  cfg_bits_i,
    input  logic        cfg_stop_bits_i,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    input  logic        rx_ready_i,
    output logic        err_parity_o,
    output logic        err_frame_o,
    output logic        err_overrun_o
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop1,
        StStop2
    } state_e;

    // -----------------------------------------------------------------------
    // Input synchroniser; flops reset to the idle level.
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx_i};
        end
    end

    logic w_line;
    logic w_line_next;
    logic w_fall;

    assign w_line      = r_sync[SYNC_STAGES-1];
    assign w_line_next = r_sync[SYNC_STAGES-2];
    // The falling edge is taken from the last two stages, so START is entered
    // on the same edge at which line goes low. The START sample then lands
    // inside the start bit even when the bit period is a single clock.
    assign w_fall      = w_line & ~w_line_next;

    // -----------------------------------------------------------------------
    // Frame FSM and datapath registers
    // -----------------------------------------------------------------------
    state_e      r_state, w_state_d;
    logic [15:0] r_baud, w_baud_d;
    logic [2:0]  r_bitcnt, w_bitcnt_d;
    logic [7:0]  r_shift, w_shift_d;
    logic        r_par_acc, w_par_acc_d;
    logic        r_perr, w_perr_d;
    logic        r_ferr, w_ferr_d;
    logic        r_done, w_done_d;
    // Configuration latched at the start edge, constant for the whole frame.
    logic [15:0] r_div, w_div_d;
    logic        r_par_en, w_par_en_d;
    logic [1:0]  r_bits, w_bits_d;
    logic        r_stop2, w_stop2_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= StIdle;
            r_baud    <= '0;
            r_bitcnt  <= '0;
            r_shift   <= '0;
            r_par_acc <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_done    <= 1'b0;
            r_div     <= '0;
            r_par_en  <= 1'b0;
            r_bits    <= '0;
            r_stop2   <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_baud    <= w_baud_d;
            r_bitcnt  <= w_bitcnt_d;
            r_shift   <= w_shift_d;
            r_par_acc <= w_par_acc_d;
            r_perr    <= w_perr_d;
            r_ferr    <= w_ferr_d;
            r_done    <= w_done_d;
            r_div     <= w_div_d;
            r_par_en  <= w_par_en_d;
            r_bits    <= w_bits_d;
            r_stop2   <= w_stop2_d;
        end
    end

    logic w_tick;
    logic w_half_tick;
    logic w_last_bit;

    assign w_tick      = (r_baud == r_div);
    assign w_half_tick = (r_baud == {1'b0, r_div[15:1]});
    assign w_last_bit  = (r_bitcnt == (3'd4 + {1'b0, r_bits}));

    always_comb begin
        w_state_d   = r_state;
        w_baud_d    = r_baud;
        w_bitcnt_d  = r_bitcnt;
        w_shift_d   = r_shift;
        w_par_acc_d = r_par_acc;
        w_perr_d    = r_perr;
        w_ferr_d    = r_ferr;
        w_done_d    = 1'b0;
        w_div_d     = r_div;
        w_par_en_d  = r_par_en;
        w_bits_d    = r_bits;
        w_stop2_d   = r_stop2;

        unique case (r_state)
            StIdle: begin
                if (cfg_en_i && w_fall) begin
                    w_state_d   = StStart;
                    w_baud_d    = '0;
                    w_bitcnt_d  = '0;
                    w_shift_d   = '0;
                    w_par_acc_d = 1'b0;
                    w_perr_d    = 1'b0;
                    w_ferr_d    = 1'b0;
                    w_div_d     = cfg_div_i;
                    w_par_en_d  = cfg_parity_en_i;
                    w_bits_d    = cfg_bits_i;
                    w_stop2_d   = cfg_stop_bits_i;
                end
            end

            StStart: begin
                if (w_half_tick) begin
                    w_baud_d  = '0;
                    // A line already back high mid-start-bit was a glitch.
                    w_state_d = w_line ? StIdle : StData;
                end else begin
                    w_baud_d = r_baud + 16'd1;
                end
            end

            StData: begin
                if (w_tick) begin
                    w_baud_d            = '0;
                    w_shift_d[r_bitcnt] = w_line;
                    w_par_acc_d         = r_par_acc ^ w_line;
                    if (w_last_bit) begin
                        w_bitcnt_d = '0;
                        w_state_d  = r_par_en ? StParity : StStop1;
                    end else begin
                        w_bitcnt_d = r_bitcnt + 3'd1;
                    end
                end else begin
                    w_baud_d = r_baud + 16'd1;
                end
            end

            StParity: begin
                if (w_tick) begin
                    w_baud_d  = '0;
                    w_perr_d  = w_line ^ r_par_acc;
                    w_state_d = StStop1;
                end else begin
                    w_baud_d = r_baud + 16'd1;
                end
            end

            StStop1: begin
                if (w_tick) begin
                    w_baud_d = '0;
                    w_ferr_d = r_ferr | ~w_line;
                    if (r_stop2) begin
                        w_state_d = StStop2;
                    end else begin
                        w_state_d = StIdle;
                        w_done_d  = 1'b1;
                    end
                end else begin
                    w_baud_d = r_baud + 16'd1;
                end
            end

            StStop2: begin
                if (w_tick) begin
                    w_baud_d  = '0;
                    w_ferr_d  = r_ferr | ~w_line;
                    w_state_d = StIdle;
                    w_done_d  = 1'b1;
                end else begin
                    w_baud_d = r_baud + 16'd1;
                end
            end

            default: begin
                w_state_d = StIdle;
            end
        endcase

        // Disabling drops whatever frame is in flight; the held word is untouched.
        if (!cfg_en_i) begin
            w_state_d  = StIdle;
            w_baud_d   = '0;
            w_bitcnt_d = '0;
            w_done_d   = 1'b0;
        end
    end

    assign busy_o = (r_state != StIdle);

    // -----------------------------------------------------------------------
    // Output holding register. Loaded the cycle after a frame completes.
    // -----------------------------------------------------------------------
    logic [7:0] r_data;
    logic       r_valid;
    logic       r_err_par;
    logic       r_err_frame;
    logic       r_overrun;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_err_par   <= 1'b0;
            r_err_frame <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_done) begin
                r_data      <= r_shift;
                r_err_par   <= r_perr;
                r_err_frame <= r_ferr;
                r_valid     <= 1'b1;
                // Accepted in the same cycle means the old word was consumed.
                r_overrun   <= r_valid & ~rx_ready_i;
            end else if (r_valid && rx_ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data_o     = r_data;
    assign rx_valid_o    = r_valid;
    assign err_parity_o  = r_err_par;
    assign err_frame_o   = r_err_frame;
    assign err_overrun_o = r_overrun;

endmodule

// File: tb/tb_mpsoc_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_mpsoc_uart_rx
//   Directed and randomised frames driven onto rx_i; the expected word and
//   error flags come from a frame-level model of the UART format.
// ---------------------------------------------------------------------------
module tb_mpsoc_uart_rx;

    logic        clk;
    logic        rst;
    logic        rx;
    logic        busy;
    logic        cfg_en;
    logic [15:0] cfg_div;
    logic        cfg_par_en;
    logic [1:0]  cfg_bits;
    logic        cfg_stop2;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        err_par;
    logic        err_frame;
    logic        err_ovr;

    int n_checks = 0;
    int n_err    = 0;
    int ov_cnt   = 0;
    bit tx_q[$];

    mpsoc_uart_rx #(
        .SYNC_STAGES(2)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .rx_i           (rx),
        .busy_o         (busy),
        .cfg_en_i       (cfg_en),
        .cfg_div_i      (cfg_div),
        .cfg_parity_en_i(cfg_par_en),
        .cfg_bits_i     (cfg_bits),
        .cfg_stop_bits_i(cfg_stop2),
        .rx_data_o      (rx_data),
        .rx_valid_o     (rx_valid),
        .rx_ready_i     (rx_ready),
        .err_parity_o   (err_par),
        .err_frame_o    (err_frame),
        .err_overrun_o  (err_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts overrun cycles; a single one-cycle pulse adds exactly one.
    always @(negedge clk) begin
        if (err_ovr === 1'b1) ov_cnt++;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Serial bit sequence for one frame, in line order.
    task automatic build(input logic [7:0] data, input int nb, input bit pen, input bit pbit,
                         input bit stop2, input bit s1, input bit s2);
        tx_q.delete();
        tx_q.push_back(1'b0);
        for (int i = 0; i < nb; i++) tx_q.push_back(data[i]);
        if (pen) tx_q.push_back(pbit);
        tx_q.push_back(s1);
        if (stop2) tx_q.push_back(s2);
    endtask

    // Drives the first n queued bits, each for div+1 clocks, then idles high.
    task automatic drive(input int div, input int n);
        for (int k = 0; k < n; k++) begin
            rx = tx_q[k];
            repeat (div + 1) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic set_cfg(input int div, input int nb, input bit pen, input bit stop2);
        cfg_div    = 16'(div);
        cfg_bits   = 2'(nb - 5);
        cfg_par_en = pen;
        cfg_stop2  = stop2;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int i = 0;
        while (rx_valid !== 1'b1 && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk(tag, 16'(rx_valid), 16'd1);
    endtask

    task automatic consume(input string tag);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk(tag, 16'(rx_valid), 16'd0);
    endtask

    // Sends one full frame and checks the delivered word against the model.
    task automatic send_check(input string tag, input int div, input logic [7:0] data,
                              input int nb, input bit pen, input bit pbit, input bit stop2,
                              input bit s1, input bit s2);
        logic [7:0] mask;
        logic [7:0] exp_data;
        bit         exp_perr;
        bit         exp_ferr;
        mask     = 8'((9'd1 << nb) - 9'd1);
        exp_data = data & mask;
        exp_perr = pen && (pbit != (^exp_data));
        exp_ferr = !s1 || (stop2 && !s2);
        set_cfg(div, nb, pen, stop2);
        build(data, nb, pen, pbit, stop2, s1, s2);
        drive(div, tx_q.size());
        wait_valid({tag, "_valid"}, 4 * (div + 1) + 20);
        chk({tag, "_data"}, 16'(rx_data), 16'(exp_data));
        chk({tag, "_perr"}, 16'(err_par), 16'(exp_perr));
        chk({tag, "_ferr"}, 16'(err_frame), 16'(exp_ferr));
        chk({tag, "_busy"}, 16'(busy), 16'd0);
    endtask

    initial begin
        int ov0;
        rst      = 1'b1;
        rx       = 1'b1;
        rx_ready = 1'b0;
        cfg_en   = 1'b1;
        set_cfg(15, 8, 1'b0, 1'b0);
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_valid", 16'(rx_valid), 16'd0);
        chk("rst_data", 16'(rx_data), 16'd0);
        chk("rst_perr", 16'(err_par), 16'd0);
        chk("rst_ferr", 16'(err_frame), 16'd0);
        chk("rst_ovr", 16'(err_ovr), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Basic 8N1 frame
        send_check("a5", 15, 8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        consume("a5_consume");

        // 5 data bits, even parity, wrong parity bit sent
        send_check("par13", 7, 8'h13, 5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("par13_perr_lit", 16'(err_par), 16'd1);
        consume("par13_consume");

        // Two stop bits, second one low
        send_check("stop2", 3, 8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("stop2_ferr_lit", 16'(err_frame), 16'd1);
        consume("stop2_consume");

        // One-clock bit period
        send_check("div0", 0, 8'h2D, 6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        consume("div0_consume");

        // Start-bit glitch shorter than half a bit period
        set_cfg(15, 8, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        chk("glitch_busy_hi", 16'(busy), 16'd1);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        chk("glitch_busy_lo", 16'(busy), 16'd0);
        chk("glitch_valid", 16'(rx_valid), 16'd0);

        // Back-to-back frames, nothing consumed
        ov0 = ov_cnt;
        build(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        drive(15, tx_q.size());
        build(8'h22, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        drive(15, tx_q.size());
        repeat (40) @(negedge clk);
        chk("ovr_pulses", 16'(ov_cnt - ov0), 16'd1);
        chk("ovr_data", 16'(rx_data), 16'h22);
        chk("ovr_valid", 16'(rx_valid), 16'd1);
        consume("ovr_consume");

        // Disable mid-frame leaves the held word alone
        send_check("hold77", 15, 8'h77, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        build(8'h99, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        drive(15, 4);
        cfg_en = 1'b0;
        @(negedge clk);
        chk("dis_busy", 16'(busy), 16'd0);
        repeat (5) @(negedge clk);
        cfg_en = 1'b1;
        repeat (200) @(negedge clk);
        chk("dis_busy_after", 16'(busy), 16'd0);
        chk("dis_valid", 16'(rx_valid), 16'd1);
        chk("dis_data", 16'(rx_data), 16'h77);

        // Reset in the middle of DATA, with a word still held
        build(8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        drive(15, 4);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_valid", 16'(rx_valid), 16'd0);
        chk("mrst_data", 16'(rx_data), 16'd0);
        chk("mrst_perr", 16'(err_par), 16'd0);
        chk("mrst_ferr", 16'(err_frame), 16'd0);
        chk("mrst_ovr", 16'(err_ovr), 16'd0);
        chk("mrst_busy", 16'(busy), 16'd0);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        chk("mrst_no_word", 16'(rx_valid), 16'd0);
        send_check("f3c", 15, 8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        consume("f3c_consume");

        // Randomised frames
        for (int f = 0; f < 12; f++) begin
            int         div;
            int         nb;
            bit         pen;
            bit         stop2;
            bit         pbit;
            bit         s1;
            bit         s2;
            logic [7:0] data;
            logic [7:0] mask;
            div   = int'($urandom_range(0, 12));
            nb    = 5 + int'($urandom_range(0, 3));
            pen   = 1'($urandom_range(0, 1));
            stop2 = 1'($urandom_range(0, 1));
            data  = 8'($urandom);
            mask  = 8'((9'd1 << nb) - 9'd1);
            pbit  = (^(data & mask)) ^ ($urandom_range(0, 3) == 0);
            s1    = ($urandom_range(0, 4) != 0);
            s2    = ($urandom_range(0, 4) != 0);
            send_check($sformatf("rnd%0d", f), div, data, nb, pen, pbit, stop2, s1, s2);
            consume($sformatf("rnd%0d_consume", f));
            repeat (3) @(negedge clk);
        end

        chk("ovr_total", 16'(ov_cnt), 16'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
